// File: rtl/noise_prob_pkg.sv
// Shared defaults and the in-flight read tag for the noise-probability
// memory read scheduler.
package noise_prob_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int ADDR_W_DEF  = 14;
    localparam int DATA_W_DEF  = 64;
    localparam int DEPTH_DEF   = 8960;
    localparam int RD_LAT_DEF  = 1;

    // Wide enough for the largest supported channel count (8).
    localparam int IDX_W = 3;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             oor;
    } tag_t;

endpackage

// File: rtl/noise_prob_rd_sched_if.sv
// Channel-side request/response bus plus memory port-2 signals for the
// noise-probability read scheduler.
interface noise_prob_rd_sched_if
    import noise_prob_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
);
    logic [NUM_REQ-1:0]             req;
    logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]             gnt;
    logic [NUM_REQ-1:0]             rvalid;
    logic [DATA_W-1:0]              rdata;
    logic                           rerr;
    logic                           freeze_req;
    logic                           freeze_ack;
    logic [ADDR_W-1:0]              mem_address;
    logic                           mem_chipselect;
    logic                           mem_clken;
    logic                           mem_write;
    logic [7:0]                     mem_byteenable;
    logic [DATA_W-1:0]              mem_readdata;

    modport slave (
        input  req, req_addr, freeze_req, mem_readdata,
        output gnt, rvalid, rdata, rerr, freeze_ack,
               mem_address, mem_chipselect, mem_clken, mem_write, mem_byteenable
    );

    modport master (
        output req, req_addr, freeze_req, mem_readdata,
        input  gnt, rvalid, rdata, rerr, freeze_ack,
               mem_address, mem_chipselect, mem_clken, mem_write, mem_byteenable
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// ptr, wrapping modulo NUM_REQ.
module rr_arbiter
    import noise_prob_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               any_gnt
);

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any_gnt = 1'b0;
        // Walk offsets from ptr; the inner compare keeps every bit select constant.
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (i == (int'(ptr) + k) % NUM_REQ && en && req[i] && !any_gnt) begin
                    gnt[i]  = 1'b1;
                    gnt_idx = IDX_W'(i);
                    any_gnt = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/noise_prob_rd_sched.sv
// Round-robin read scheduler for port 2 of the noise-probability memory:
// one read issued per cycle, responses routed back in order, freeze handshake.
module noise_prob_rd_sched
    import noise_prob_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int RD_LAT  = RD_LAT_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    noise_prob_rd_sched_if.slave  bus
);

    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               any_gnt;
    logic [ADDR_W-1:0]  gnt_addr;
    logic               gnt_oor;

    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ADDR_W-1:0]  mem_address_q, mem_address_d;
    logic               mem_cs_q, mem_cs_d;
    logic [RD_LAT:0]    vld_pipe_q, vld_pipe_d;
    tag_t [RD_LAT:0]    tag_pipe_q, tag_pipe_d;
    tag_t               out_tag;
    logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               rerr_q, rerr_d;
    logic               freeze_ack_q, freeze_ack_d;

    // Gating with reset_n keeps the combinational grant low while in reset.
    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req     (bus.req),
        .en      (reset_n & ~bus.freeze_req),
        .ptr     (rr_ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any_gnt (any_gnt)
    );

    always_comb begin
        gnt_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) gnt_addr = bus.req_addr[i];
        end
        gnt_oor = {1'b0, gnt_addr} >= (ADDR_W+1)'(DEPTH);
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (any_gnt) begin
            rr_ptr_d = (gnt_idx == IDX_W'(NUM_REQ-1)) ? '0 : gnt_idx + IDX_W'(1);
        end

        // Out-of-range reads keep chipselect low but still take a pipeline slot.
        mem_address_d = any_gnt ? gnt_addr : mem_address_q;
        mem_cs_d      = any_gnt & ~gnt_oor;

        vld_pipe_d[0]     = any_gnt;
        tag_pipe_d[0].idx = gnt_idx;
        tag_pipe_d[0].oor = gnt_oor;
        for (int s = 1; s <= RD_LAT; s++) begin
            vld_pipe_d[s] = vld_pipe_q[s-1];
            tag_pipe_d[s] = tag_pipe_q[s-1];
        end
    end

    // The last stage lines up with mem_readdata for the read it describes.
    always_comb begin
        out_tag  = tag_pipe_q[RD_LAT];
        rvalid_d = '0;
        rdata_d  = rdata_q;
        rerr_d   = rerr_q;
        if (vld_pipe_q[RD_LAT]) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                rvalid_d[i] = (out_tag.idx == IDX_W'(i));
            end
            rdata_d = out_tag.oor ? '0 : bus.mem_readdata;
            rerr_d  = out_tag.oor;
        end
        freeze_ack_d = bus.freeze_req & ~|vld_pipe_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q      <= '0;
            mem_address_q <= '0;
            mem_cs_q      <= 1'b0;
            vld_pipe_q    <= '0;
            tag_pipe_q    <= '0;
            rvalid_q      <= '0;
            rdata_q       <= '0;
            rerr_q        <= 1'b0;
            freeze_ack_q  <= 1'b0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            mem_address_q <= mem_address_d;
            mem_cs_q      <= mem_cs_d;
            vld_pipe_q    <= vld_pipe_d;
            tag_pipe_q    <= tag_pipe_d;
            rvalid_q      <= rvalid_d;
            rdata_q       <= rdata_d;
            rerr_q        <= rerr_d;
            freeze_ack_q  <= freeze_ack_d;
        end
    end

    assign bus.gnt            = gnt;
    assign bus.rvalid         = rvalid_q;
    assign bus.rdata          = rdata_q;
    assign bus.rerr           = rerr_q;
    assign bus.freeze_ack     = freeze_ack_q;
    assign bus.mem_address    = mem_address_q;
    assign bus.mem_chipselect = mem_cs_q;
    assign bus.mem_clken      = 1'b1;
    assign bus.mem_write      = 1'b0;
    assign bus.mem_byteenable = 8'hFF;

endmodule

// File: tb/tb_noise_prob_rd_sched.sv
// Table-driven bench for noise_prob_rd_sched with a response scoreboard and a
// behavioural single-cycle-latency RAM on port 2.
module tb_noise_prob_rd_sched;
    import noise_prob_pkg::*;

    localparam int NR    = 4;
    localparam int AW    = 14;
    localparam int DW    = 64;
    localparam int DEPTH = 8960;
    localparam logic [31:0] ROT = 32'h8421_8421;

    typedef struct {
        logic [NR-1:0]         req;
        logic [NR-1:0][AW-1:0] addr;
        logic                  frz;
        logic [NR-1:0]         gnt;
        int                    ack;
        bit                    nrv;
    } vec_t;

    typedef struct {
        int            due;
        logic [NR-1:0] vld;
        logic [DW-1:0] data;
        logic          err;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    noise_prob_rd_sched_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

    noise_prob_rd_sched #(
        .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .RD_LAT(1)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    exp_t sb[$];
    vec_t tbl[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_chk = 0;
    int   step = 0;
    logic          prev_g;
    logic [AW-1:0] prev_a;
    logic          prev_oor;

    function automatic logic [DW-1:0] mem_word(logic [AW-1:0] a);
        return {16'hC0DE, 2'b00, a, ~{18'd0, a}};
    endfunction

    // Preloaded RAM contents are a pure function of the address.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset_n)                bus.mem_readdata <= 64'hFFFF_EEEE_DDDD_CCCC;
        else if (bus.mem_chipselect) bus.mem_readdata <= mem_word(bus.mem_address);
    end

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    function automatic vec_t mk(logic [NR-1:0] r, logic [AW-1:0] a0, logic [AW-1:0] a1,
                                logic [AW-1:0] a2, logic [AW-1:0] a3, logic f,
                                logic [NR-1:0] g, int ack = -1);
        vec_t v;
        v.req = r;
        v.addr[0] = a0; v.addr[1] = a1; v.addr[2] = a2; v.addr[3] = a3;
        v.frz = f; v.gnt = g; v.ack = ack; v.nrv = 1'b0;
        return v;
    endfunction

    function automatic vec_t idle(int ack = -1);
        return mk('0, '0, '0, '0, '0, 1'b0, '0, ack);
    endfunction

    task automatic chk_reset(string nm);
        chk({nm, " gnt"},     64'(bus.gnt), 64'd0);
        chk({nm, " rvalid"},  64'(bus.rvalid), 64'd0);
        chk({nm, " rdata"},   bus.rdata, 64'd0);
        chk({nm, " rerr"},    64'(bus.rerr), 64'd0);
        chk({nm, " ack"},     64'(bus.freeze_ack), 64'd0);
        chk({nm, " addr"},    64'(bus.mem_address), 64'd0);
        chk({nm, " cs"},      64'(bus.mem_chipselect), 64'd0);
        chk({nm, " clken"},   64'(bus.mem_clken), 64'd1);
        chk({nm, " write"},   64'(bus.mem_write), 64'd0);
        chk({nm, " byteen"},  64'(bus.mem_byteenable), 64'hFF);
    endtask

    // One cycle: drive at posedge+1, check at negedge, queue the expected response.
    task automatic apply(vec_t v);
        exp_t e;
        bus.req        = v.req;
        bus.req_addr   = v.addr;
        bus.freeze_req = v.frz;
        @(negedge clk);
        chk($sformatf("gnt s%0d", step), 64'(bus.gnt), 64'(v.gnt));
        chk($sformatf("mem_cs s%0d", step), 64'(bus.mem_chipselect), 64'(prev_g & ~prev_oor));
        if (prev_g) chk($sformatf("mem_addr s%0d", step), 64'(bus.mem_address), 64'(prev_a));
        if (v.ack >= 0) chk($sformatf("freeze_ack s%0d", step), 64'(bus.freeze_ack), 64'(v.ack));
        if (v.nrv) chk($sformatf("no_rvalid s%0d", step), 64'(bus.rvalid), 64'd0);
        prev_g = 1'b0;
        for (int i = 0; i < NR; i++) begin
            if (v.gnt[i]) begin
                prev_g   = 1'b1;
                prev_a   = v.addr[i];
                prev_oor = v.addr[i] >= AW'(DEPTH);
                e.due  = cyc + 3;
                e.vld  = v.gnt;
                e.err  = prev_oor;
                e.data = prev_oor ? '0 : mem_word(v.addr[i]);
                sb.push_back(e);
            end
        end
        step++;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.rvalid != '0) begin
                if (sb.size() == 0) begin
                    chk("rvalid_unexpected", 64'(bus.rvalid), 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("rvalid_ch",  64'(bus.rvalid), 64'(mon_e.vld));
                    chk("rvalid_cyc", 64'(cyc), 64'(mon_e.due));
                    chk("rdata",      bus.rdata, mon_e.data);
                    chk("rerr",       64'(bus.rerr), 64'(mon_e.err));
                end
            end else if (sb.size() > 0 && cyc >= sb[0].due) begin
                chk("rvalid_missing", 64'(bus.rvalid), 64'(sb[0].vld));
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        vec_t v;
        bus.req = '0; bus.req_addr = '0; bus.freeze_req = 1'b0;
        prev_g = 1'b0; prev_a = '0; prev_oor = 1'b0;

        for (int k = 0; k < 8; k++)
            tbl.push_back(mk(4'hF, AW'(k*4), AW'(k*4+1), AW'(k*4+2), AW'(k*4+3), 1'b0, ROT[k*4 +: 4]));
        tbl.push_back(mk(4'b0100, 0, 0, 14'h0005, 0, 1'b0, 4'b0100));
        tbl.push_back(idle());
        tbl.push_back(mk(4'b0010, 0, 14'h2300, 0, 0, 1'b0, 4'b0010));
        tbl.push_back(idle());
        tbl.push_back(mk(4'b1001, 14'h10, 0, 0, 14'h30, 1'b0, 4'b1000));
        tbl.push_back(mk(4'b1001, 14'h10, 0, 0, 14'h30, 1'b0, 4'b0001));
        tbl.push_back(mk(4'b1001, 14'h10, 0, 0, 14'h30, 1'b0, 4'b1000));
        tbl.push_back(mk(4'b0101, 14'h22FF, 0, 14'h40, 0, 1'b0, 4'b0001));
        tbl.push_back(mk(4'b0100, 0, 0, 14'h40, 0, 1'b0, 4'b0100));
        tbl.push_back(mk(4'b1000, 0, 0, 0, 14'h3FFF, 1'b0, 4'b1000));
        tbl.push_back(mk(4'hF, 1, 2, 3, 4, 1'b1, 4'b0000, 0));
        tbl.push_back(idle(0));
        repeat (3) tbl.push_back(idle());
        // Two reads in flight, then freeze until the pipeline drains.
        tbl.push_back(mk(4'b0011, 14'h50, 14'h60, 0, 0, 1'b0, 4'b0001, 0));
        tbl.push_back(mk(4'b0011, 14'h50, 14'h60, 0, 0, 1'b0, 4'b0010, 0));
        repeat (3) tbl.push_back(mk(4'b0011, 14'h50, 14'h60, 0, 0, 1'b1, 4'b0000, 0));
        repeat (2) tbl.push_back(mk(4'b0011, 14'h50, 14'h60, 0, 0, 1'b1, 4'b0000, 1));
        tbl.push_back(mk(4'b0011, 14'h50, 14'h60, 0, 0, 1'b0, 4'b0001, 1));
        tbl.push_back(mk(4'b0010, 0, 14'h60, 0, 0, 1'b0, 4'b0010, 0));
        tbl.push_back(idle(0));

        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset("rst0");
        @(posedge clk);
        #1 reset_n = 1'b1;

        foreach (tbl[k]) apply(tbl[k]);

        // Channel 3 streaming alone.
        for (int k = 0; k < 5; k++) apply(mk(4'b1000, 0, 0, 0, AW'(14'h100 + k), 1'b0, 4'b1000));
        repeat (3) apply(idle());

        // Reset one cycle after a grant: the in-flight read must vanish.
        apply(mk(4'b0100, 0, 0, 14'h0007, 0, 1'b0, 4'b0100));
        reset_n = 1'b0;
        sb.delete();
        prev_g = 1'b0;
        @(negedge clk);
        chk_reset("rst1");
        @(posedge clk);
        #1 reset_n = 1'b1;
        bus.req = '0;
        for (int k = 0; k < 4; k++) begin
            v = idle();
            v.nrv = 1'b1;
            apply(v);
        end
        apply(mk(4'b1010, 0, 14'h20, 0, 14'h30, 1'b0, 4'b0010));
        for (int k = 0; k < 8 && sb.size() > 0; k++) apply(idle());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
